tetris_board_renderer: RTL and testbench
========================================

# tetris_board_renderer

Pixel-pipeline stage directly downstream of the VGA timing generator. Takes per-pixel coordinates, the active flag and sync signals, reads the 10×20 playfield from a synchronous board RAM, and overlays the falling piece. It also draws the border and palette colours, then drives 12-bit RGB with hsync/vsync delayed to stay pixel-aligned. The piece state is frame-latched so the piece never tears mid-frame.

## Interface
- ORIGIN_X, 240: x of the board's left pixel column.
- ORIGIN_Y, 80: y of the board's top pixel row.
- CELL_LOG2, 4: log2 of cell size in pixels (16×16 cells). The board is 160×320 px; columns (10) and rows (20) are fixed.
- BORDER, 4: border thickness in pixels, drawn outside the board rectangle.
- clk  in  1: pixel clock.
- rst  in  1: synchronous, active-high reset.
- x_pos, y_pos  in  10 each: pixel coordinates from the timing generator.
- active  in  1: visible-pixel flag.
- hsync, vsync  in  1 each: sync pulses, active-low.
- cell_addr  out  8: board RAM read address, row*10+col, range 0..199.
- cell_data  in  3: board RAM read data. 0 means empty; 1..7 are colour indices.
- piece_col  in  5 signed: column of the piece's 4×4 box.
- piece_row  in  6 signed: row of the piece's 4×4 box. Negative values are allowed during spawn.
- piece_mask  in  16: occupancy bit. Bit index is r*4+c, where r and c are the offset within the box.
- piece_color  in  3: colour index of the piece.
- red, green, blue  out  4 each: pixel colour.
- hsync_out, vsync_out  out  1 each: syncs delayed to match the RGB output.

## Operation
- **Frame latch:**
  - A registered copy of vsync detects the 1→0 edge.
  - On the edge cycle, shadow registers capture piece_col, piece_row, piece_mask and piece_color.
  - The overlay uses only the shadow registers. Input changes mid-frame have no visible effect until the next latch.
- **Stage 1 (edge 1):**
  - Compute dx = x_pos − ORIGIN_X and dy = y_pos − ORIGIN_Y.
  - in_board = active && 0 ≤ dx < 160 && 0 ≤ dy < 320.
  - col = dx >> CELL_LOG2, row = dy >> CELL_LOG2; the local offset is the low CELL_LOG2 bits.
  - Register cell_addr = row*10+col when in_board; otherwise hold cell_addr unchanged.
  - in_border = active && !in_board && the pixel lies within BORDER px of the board rectangle (x 236..403, y 76..403 at defaults).
  - Piece hit:
    - pr = row − piece_row and pc = col − piece_col, computed in signed 7-bit arithmetic.
    - hit = in_board && pr, pc ∈ [0,3] && piece_mask[pr*4+pc].
  - Register the stage-1 fields: in_board, in_border, hit, local_zero (local x == 0 or local y == 0), and the syncs.
- **Stage 2 (edge 2):**
  - The board RAM presents cell_data.
  - Pass the stage-1 fields through one more register.
- **Stage 3 (edge 3):** select the colour index in priority order.
  - Not active, or neither board nor border: 0x000.
  - Border: 0xFFF.
  - hit: idx = piece_color.
  - Otherwise: idx = cell_data.
  - If idx == 0: 0x111.
  - Else if local_zero: 0x000 (cell gap).
  - Else palette colour.
- **Palette:** 1 0x0FF, 2 0xFF0, 3 0xA0F, 4 0x0F0, 5 0xF00, 6 0x00F, 7 0xF80.
- **Priority:** a piece hit overrides a non-empty board cell.
- **Piece cells outside the board:** cells with pr/pc in range but row < 0 are never drawn, because in_board is false.

## Timing
- Latency from pixel input to RGB and sync outputs is exactly 3 clocks.
- hsync_out and vsync_out are the inputs delayed by exactly 3 clocks, so they stay pixel-aligned with RGB.
- cell_addr is valid 1 clock after input. The RAM returns data 1 clock after cell_addr (synchronous read).
- Reset values:
  - RGB 0x000.
  - hsync_out and vsync_out 1.
  - cell_addr 0.
  - All pipeline valid/flag bits 0; sync delay stages 1.
  - Shadow piece_mask 0 (no overlay until the first vsync fall); shadow piece_col, piece_row and piece_color 0.
  - The vsync edge detector's previous-value register resets to 1.
- Reset mid-frame: the pipeline is flushed to reset values on the next edge. The output resumes 3 clocks after rst deasserts.
- Pixels in flight when the frame latch fires use the new shadow values from that edge onward.

## Test plan
- **Reset:** hold rst 2 clocks while inputs toggle → RGB 0x000, hsync_out = vsync_out = 1, cell_addr 0. After release, no overlay appears until vsync falls.
- **Address map:**
  - x=256, y=96, active → cell_addr 11 one clock later.
  - x=399, y=399 → cell_addr 199.
  - x=400, y=200 → cell_addr holds its prior value.
- **Latency and alignment:** RAM model returns 5 for address 11; drive x=257, y=97 → RGB 0xF00 exactly 3 clocks later. An hsync 1→0 transition at the input appears on hsync_out exactly 3 clocks later.
- **Border and blanking:**
  - x=238, y=200 → 0xFFF.
  - x=100, y=200 → 0x000.
  - x=300, y=200 with active=0 → 0x000.
- **Overlay and latch:**
  - Set piece_col=3, piece_row=−1, mask bit 4, colour 2 mid-frame → no change to the frame in progress.
  - After vsync falls, x=293, y=85 (cell col3, row0, local 5,5) with RAM data 6 → 0xFF0.
  - Mask bit 0 (row −1) draws nothing.
- **Cell gap:**
  - x=256 (local x 0), y=100, RAM data 4 → 0x000.
  - Same pixel with RAM data 0 → 0x111.
  - x=257 with RAM data 4 → 0x0F0.

Source files
------------

// File: rtl/tetris_board_renderer.sv
// Pixel stage after the VGA timing generator: board RAM lookup, falling-piece overlay,
// border and palette, with syncs delayed to stay aligned with the 3-clock RGB path.
module tetris_board_renderer #(
  parameter int ORIGIN_X  = 240,
  parameter int ORIGIN_Y  = 80,
  parameter int CELL_LOG2 = 4,
  parameter int BORDER    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  input  logic              active,
  input  logic              hsync,
  input  logic              vsync,
  output logic [7:0]        cell_addr,
  input  logic [2:0]        cell_data,
  input  logic signed [4:0] piece_col,
  input  logic signed [5:0] piece_row,
  input  logic [15:0]       piece_mask,
  input  logic [2:0]        piece_color,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam logic signed [11:0] OX = 12'(ORIGIN_X);
  localparam logic signed [11:0] OY = 12'(ORIGIN_Y);
  localparam logic signed [11:0] BW = 12'(10 << CELL_LOG2);
  localparam logic signed [11:0] BH = 12'(20 << CELL_LOG2);
  localparam logic signed [11:0] BD = 12'(BORDER);

  typedef struct packed {
    logic in_board;
    logic in_border;
    logic hit;
    logic local_zero;
    logic hs;
    logic vs;
  } stage_t;

  localparam stage_t STAGE_RST = '{in_board: 1'b0, in_border: 1'b0, hit: 1'b0,
                                   local_zero: 1'b0, hs: 1'b1, vs: 1'b1};

  logic                vs_prev;
  logic signed [4:0]   sh_col;
  logic signed [5:0]   sh_row;
  logic [15:0]         sh_mask;
  logic [2:0]          sh_color;
  stage_t              s1, s2, s1_next;
  logic [11:0]         rgb_q, rgb_next;

  logic signed [11:0]  dx, dy;
  logic [3:0]          col;
  logic [4:0]          row;
  logic [6:0]          pr, pc;
  logic [7:0]          addr_next;
  logic [2:0]          idx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dx        = $signed({2'b00, x_pos}) - OX;
    dy        = $signed({2'b00, y_pos}) - OY;
    col       = dx[CELL_LOG2+3:CELL_LOG2];
    row       = dy[CELL_LOG2+4:CELL_LOG2];
    addr_next = 8'(row) * 8'd10 + 8'(col);
    // Two's-complement box offsets; bits [6:2] all zero means the offset is in 0..3.
    pr        = {2'b00, row} - {sh_row[5], sh_row};
    pc        = {3'b000, col} - {{2{sh_col[4]}}, sh_col};

    s1_next            = STAGE_RST;
    s1_next.in_board   = active && !dx[11] && (dx < BW) && !dy[11] && (dy < BH);
    s1_next.in_border  = active && !s1_next.in_board &&
                         (dx >= -BD) && (dx < BW + BD) && (dy >= -BD) && (dy < BH + BD);
    s1_next.hit        = s1_next.in_board && (pr[6:2] == 5'd0) && (pc[6:2] == 5'd0) &&
                         sh_mask[{pr[1:0], pc[1:0]}];
    s1_next.local_zero = (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);
    s1_next.hs         = hsync;
    s1_next.vs         = vsync;
  end

  function automatic logic [11:0] palette(input logic [2:0] i);
    case (i)
      3'd1:    palette = 12'h0FF;
      3'd2:    palette = 12'hFF0;
      3'd3:    palette = 12'hA0F;
      3'd4:    palette = 12'h0F0;
      3'd5:    palette = 12'hF00;
      3'd6:    palette = 12'h00F;
      3'd7:    palette = 12'hF80;
      default: palette = 12'h111;
    endcase
  endfunction

  // Stage 3 colour select; cell_data is aligned with s2 by the RAM's one-clock read.
  always_comb begin
    rgb_next = 12'h000;
    idx      = s2.hit ? sh_color : cell_data;
    if (s2.in_border) begin
      rgb_next = 12'hFFF;
    end else if (s2.in_board) begin
      if (idx == 3'd0)        rgb_next = 12'h111;
      else if (s2.local_zero) rgb_next = 12'h000;
      else                    rgb_next = palette(idx);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev   <= 1'b1;
      sh_col    <= '0;
      sh_row    <= '0;
      sh_mask   <= '0;
      sh_color  <= '0;
      cell_addr <= '0;
      s1        <= STAGE_RST;
      s2        <= STAGE_RST;
      rgb_q     <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      vs_prev <= vsync;
      if (vs_prev && !vsync) begin
        sh_col   <= piece_col;
        sh_row   <= piece_row;
        sh_mask  <= piece_mask;
        sh_color <= piece_color;
      end
      if (s1_next.in_board) cell_addr <= addr_next;
      s1        <= s1_next;
      s2        <= s1;
      rgb_q     <= rgb_next;
      hsync_out <= s2.hs;
      vsync_out <= s2.vs;
    end
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Scoreboard bench for tetris_board_renderer: directed pixels push expected RGB/sync and
// cell_addr into queues; a monitor pops and compares them when they come due.
module tb_tetris_board_renderer;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        x_pos, y_pos;
  logic              active, hsync, vsync;
  logic [7:0]        cell_addr;
  logic [2:0]        cell_data;
  logic signed [4:0] piece_col;
  logic signed [5:0] piece_row;
  logic [15:0]       piece_mask;
  logic [2:0]        piece_color;
  logic [3:0]        red, green, blue;
  logic              hsync_out, vsync_out;

  tetris_board_renderer dut (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .active(active),
    .hsync(hsync), .vsync(vsync), .cell_addr(cell_addr), .cell_data(cell_data),
    .piece_col(piece_col), .piece_row(piece_row), .piece_mask(piece_mask),
    .piece_color(piece_color), .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read board RAM model
  logic [2:0] ram [200];
  always @(posedge clk) cell_data <= (cell_addr < 8'd200) ? ram[cell_addr] : 3'd0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       name;
  } rgb_exp_t;

  typedef struct {
    int          due;
    logic [7:0]  addr;
    string       name;
  } addr_exp_t;

  rgb_exp_t  rgb_q[$];
  addr_exp_t addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every expectation on the falling edge of the cycle it comes due
  always @(negedge clk) begin
    rgb_exp_t  re;
    addr_exp_t ae;
    while (rgb_q.size() > 0 && rgb_q[0].due <= cyc) begin
      re = rgb_q.pop_front();
      check({re.name, " rgb"}, {4'h0, red, green, blue}, {4'h0, re.rgb});
      check({re.name, " sync"}, {14'h0, hsync_out, vsync_out}, {14'h0, re.hs, re.vs});
    end
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      ae = addr_q.pop_front();
      check({ae.name, " cell_addr"}, {8'h0, cell_addr}, {8'h0, ae.addr});
    end
  end

  task automatic pixel(input string name, input int x, input int y, input bit act,
                       input bit hs, input bit vs, input logic [11:0] exp,
                       input bit chk_addr = 1'b0, input int exp_addr = 0);
    x_pos  = 10'(x);
    y_pos  = 10'(y);
    active = act;
    hsync  = hs;
    vsync  = vs;
    rgb_q.push_back('{due: cyc + 3, rgb: exp, hs: hs, vs: vs, name: name});
    if (chk_addr) addr_q.push_back('{due: cyc + 1, addr: 8'(exp_addr), name: name});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pixel("blank", 0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
  endtask

  // Let reads in flight finish before rewriting a RAM word
  task automatic set_ram(input int a, input logic [2:0] v);
    idle(3);
    ram[a] = v;
  endtask

  // One clock with rst held and inputs toggling; outputs must show reset values
  task automatic rst_cycle(input string name, input bit phase);
    x_pos  = phase ? 10'd257 : 10'd399;
    y_pos  = phase ? 10'd97  : 10'd399;
    active = 1'b1;
    hsync  = phase;
    vsync  = phase;
    rgb_q.push_back('{due: cyc + 1, rgb: 12'h000, hs: 1'b1, vs: 1'b1, name: name});
    addr_q.push_back('{due: cyc + 1, addr: 8'd0, name: name});
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (rgb_q.size() + addr_q.size()) > 0; i++) @(negedge clk);
    check("scoreboard drained", 16'(rgb_q.size() + addr_q.size()), 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 200; i++) ram[i] = 3'd0;
    ram[11] = 3'd5;
    ram[3]  = 3'd6;
    ram[4]  = 3'd3;
    rst = 1'b1;
    x_pos = '0; y_pos = '0; active = 1'b0; hsync = 1'b1; vsync = 1'b1;
    // A full-box piece that must stay invisible until a vsync fall latches it
    piece_col = 5'sd0; piece_row = 6'sd0; piece_mask = 16'hFFFF; piece_color = 3'd1;

    @(negedge clk);
    rst_cycle("reset a", 1'b0);
    rst_cycle("reset b", 1'b1);
    rst = 1'b0;

    // Address map, latency, sync alignment, border and blanking
    pixel("addr 11 gap",    256,  96, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 11);
    pixel("latency F00",    257,  97, 1'b1, 1'b0, 1'b1, 12'hF00, 1'b1, 11);
    pixel("addr 199 empty", 399, 399, 1'b1, 1'b0, 1'b1, 12'h111, 1'b1, 199);
    pixel("right border",   400, 200, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 199);
    pixel("left border",    238, 200, 1'b1, 1'b1, 1'b1, 12'hFFF);
    pixel("outside",        100, 200, 1'b1, 1'b1, 1'b1, 12'h000);
    pixel("inactive",       300, 200, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 199);

    // Cell gap and empty cells
    set_ram(11, 3'd4);
    pixel("gap local x0",   256, 100, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 11);
    pixel("cell colour 4",  257, 100, 1'b1, 1'b1, 1'b1, 12'h0F0);
    set_ram(11, 3'd0);
    pixel("empty at gap",   256, 100, 1'b1, 1'b1, 1'b1, 12'h111);

    // Piece inputs change mid-frame: nothing visible until vsync falls
    piece_col = 5'sd3; piece_row = -6'sd1; piece_mask = 16'h0011; piece_color = 3'd2;
    pixel("pre-latch cell", 293,  85, 1'b1, 1'b1, 1'b1, 12'h00F, 1'b1, 3);
    pixel("pre-latch nbr",  309,  85, 1'b1, 1'b1, 1'b1, 12'hA0F, 1'b1, 4);
    pixel("vsync fall",       0,   0, 1'b0, 1'b1, 1'b0, 12'h000);
    pixel("overlay hit",    293,  85, 1'b1, 1'b1, 1'b1, 12'hFF0);
    pixel("beside piece",   309,  85, 1'b1, 1'b1, 1'b1, 12'hA0F);
    pixel("row -1 border",  293,  78, 1'b1, 1'b1, 1'b1, 12'hFFF);
    pixel("row -1 outside", 293,  70, 1'b1, 1'b1, 1'b1, 12'h000);
    pixel("piece gap",      288,  85, 1'b1, 1'b1, 1'b1, 12'h000);
    piece_mask = 16'h0000;
    pixel("held mid-frame", 293,  85, 1'b1, 1'b1, 1'b1, 12'hFF0);
    drain();

    // Reset mid-frame clears the shadow piece; output resumes right after release
    rst = 1'b1;
    rst_cycle("mid reset a", 1'b0);
    rst_cycle("mid reset b", 1'b1);
    rst = 1'b0;
    pixel("after reset",    293,  85, 1'b1, 1'b1, 1'b1, 12'h00F, 1'b1, 3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
